// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller, AluControl and benches.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package multicycle_control_pkg;

    // Instruction opcodes; aluop uses the same encoding.
    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;
    localparam logic [2:0] OP_J   = 3'b100;

    // Controller states.
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Opcodes above OP_J are illegal.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_J;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB FSM with combinational output decode.
// Latency: R=4, lw=5, sw=4, beq=3, j=3 cycles fetch-to-retire; each mem_ready stall adds one.
// Backpressure: mem_ready low holds FETCH or MEM with the same outputs until the access completes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    input  logic               zero,
    output logic [ALUOP_W-1:0] aluop,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               jump,
    output logic               retire,
    output logic               illegal
);

    localparam logic [OP_W-1:0] L_R   = OP_W'(OP_R);
    localparam logic [OP_W-1:0] L_LW  = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] L_SW  = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] L_BEQ = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] L_J   = OP_W'(OP_J);

    logic [2:0]      state_q, state_d;
    logic [OP_W-1:0] op_q;

    // State register; reset always restarts at FETCH, aborting any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the opcode as DECODE is left so later IR changes cannot disturb EXEC/MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
        end else if (state_q == ST_DECODE) begin
            op_q <= opcode;
        end
    end

    // Next-state and output decode; everything not asserted by a state stays 0, all 0 during reset.
    always_comb begin
        state_d       = state_q;
        aluop         = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        jump          = 1'b0;
        retire        = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // aluop stays 000: the ALU forms PC+1.
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Decode uses the live IR field; the register copy is not loaded yet.
                if (opcode <= L_J) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                aluop = ALUOP_W'(op_q);
                if (op_q == L_R) begin
                    state_d = ST_WB;
                end else if (op_q == L_LW || op_q == L_SW) begin
                    alu_src = 1'b1;
                    state_d = ST_MEM;
                end else if (op_q == L_BEQ) begin
                    pc_write_cond = zero;
                    retire        = 1'b1;
                    state_d       = ST_FETCH;
                end else if (op_q == L_J) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    // Unreachable: DECODE filters illegal opcodes.
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                aluop = ALUOP_W'(op_q);
                if (op_q == L_LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (op_q == L_LW) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == L_LW);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst) begin
            aluop         = '0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src       = 1'b0;
            jump          = 1'b0;
            retire        = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver pushes per-cycle expected outputs, monitor compares.
// Latency: n/a.
// Backpressure: mem_ready stalls randomized in FETCH and MEM.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic [2:0] aluop;
    logic pc_write, pc_write_cond, ir_write, mem_read, mem_write;
    logic reg_write, mem_to_reg, alu_src, jump, retire, illegal;

    multicycle_control #(.OP_W(3), .ALUOP_W(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .aluop(aluop), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .jump(jump), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected-vector layout: [13:11] aluop, then one bit per control output.
    localparam logic [13:0] PCW  = 14'(1) << 10;
    localparam logic [13:0] PCWC = 14'(1) << 9;
    localparam logic [13:0] IRW  = 14'(1) << 8;
    localparam logic [13:0] MR   = 14'(1) << 7;
    localparam logic [13:0] MW   = 14'(1) << 6;
    localparam logic [13:0] RW   = 14'(1) << 5;
    localparam logic [13:0] M2R  = 14'(1) << 4;
    localparam logic [13:0] ASRC = 14'(1) << 3;
    localparam logic [13:0] JMP  = 14'(1) << 2;
    localparam logic [13:0] RET  = 14'(1) << 1;
    localparam logic [13:0] ILL  = 14'(1) << 0;

    function automatic logic [13:0] al(input logic [2:0] op);
        return {op, 11'b0};
    endfunction

    logic [13:0] exp_q[$];
    string       tag_q[$];
    int tests  = 0;
    int failed = 0;
    int retires = 0;

    // Monitor: every cycle with a pending expectation, compare all outputs at the falling edge.
    always @(negedge clk) begin
        logic [13:0] act, e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            act = {aluop, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                   reg_write, mem_to_reg, alu_src, jump, retire, illegal};
            tests++;
            if (act !== e) begin
                failed++;
                $display("FAIL %s: outputs got %b expected %b", t, act, e);
            end
            if (act[1] === 1'b1) retires++;
        end
    end

    // Drive one cycle of inputs and record what the outputs must be during it.
    task automatic cyc(input logic r, input logic rdy, input logic [2:0] op, input logic z,
                       input logic [13:0] e, input string t);
        rst       = r;
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction as a timeline: fetch (with stalls), decode, execute, then memory and
    // write-back only when the instruction needs them. The opcode input is scrambled outside
    // DECODE so a controller that fails to hold the decoded opcode is caught.
    task automatic run_instr(input logic [2:0] op, input int fs, input int ms, input logic z);
        logic [13:0] memv;
        for (int i = 0; i < fs; i++) cyc(0, 0, rop(), rb(), MR, "fetch_stall");
        cyc(0, 1, rop(), rb(), MR | IRW | PCW, "fetch");
        if (op > OP_J) begin
            cyc(0, rb(), op, rb(), ILL, "decode_illegal");
            return;
        end
        cyc(0, rb(), op, rb(), '0, "decode");
        case (op)
            OP_R:   cyc(0, rb(), rop(), rb(), al(op), "exec_r");
            OP_LW:  cyc(0, rb(), rop(), rb(), al(op) | ASRC, "exec_lw");
            OP_SW:  cyc(0, rb(), rop(), rb(), al(op) | ASRC, "exec_sw");
            OP_BEQ: cyc(0, rb(), rop(), z, al(op) | (z ? PCWC : 14'd0) | RET, "exec_beq");
            default: cyc(0, rb(), rop(), rb(), al(op) | JMP | PCW | RET, "exec_j");
        endcase
        if (op == OP_LW || op == OP_SW) begin
            memv = al(op) | ((op == OP_LW) ? MR : MW);
            for (int i = 0; i < ms; i++) cyc(0, 0, rop(), rb(), memv, "mem_stall");
            cyc(0, 1, rop(), rb(), memv | ((op == OP_SW) ? RET : 14'd0), "mem_done");
        end
        if (op == OP_R || op == OP_LW)
            cyc(0, rb(), rop(), rb(), RW | ((op == OP_LW) ? M2R : 14'd0) | RET, "wb");
    endtask

    initial begin
        int n_ret;
        rst = 1'b1; mem_ready = 1'b1; opcode = 3'b000; zero = 1'b0;
        @(posedge clk);
        #1;
        // Reset held two cycles with mem_ready high: every output quiet.
        cyc(1, 1, 3'b000, 0, '0, "reset0");
        cyc(1, 1, 3'b000, 0, '0, "reset1");

        // Directed cases.
        run_instr(OP_R, 0, 0, 0);
        run_instr(OP_LW, 0, 2, 0);
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(3'b110, 0, 0, 0);
        run_instr(OP_J, 1, 0, 0);
        run_instr(OP_SW, 0, 0, 0);

        // sw aborted by reset during a MEM stall: no write, no retire, then fresh FETCH.
        cyc(0, 1, rop(), 0, MR | IRW | PCW, "abort_fetch");
        cyc(0, 1, OP_SW, 0, '0, "abort_decode");
        cyc(0, 0, rop(), 0, al(OP_SW) | ASRC, "abort_exec");
        cyc(0, 0, rop(), 0, al(OP_SW) | MW, "abort_mem_stall");
        cyc(1, 0, rop(), 0, '0, "abort_rst0");
        cyc(1, 1, rop(), 0, '0, "abort_rst1");
        cyc(0, 1, rop(), 0, MR | IRW | PCW, "abort_refetch");
        cyc(0, 1, 3'b111, 0, ILL, "abort_decode2");

        // Reset during a fetch stall.
        cyc(0, 0, rop(), 0, MR, "fs_abort_stall");
        cyc(1, 1, rop(), 0, '0, "fs_abort_rst");
        run_instr(OP_LW, 0, 0, 0);

        // Randomized instruction stream.
        for (int k = 0; k < 300; k++)
            run_instr(rop(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
        end
        n_ret = retires;
        tests++;
        if (n_ret == 0) begin
            failed++;
            $display("FAIL retire_seen: retire pulses got %0d expected nonzero", n_ret);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
